// File: rtl/riscv_fetch.sv
// Instruction fetch stage: issues icache reads, tracks the PC, and feeds decode through a
// 1-entry skid buffer. Optional feature macro: RISCV_FETCH_FAULT_EN (adds fetch_fault_o).
module riscv_fetch #(
  parameter logic [31:0] BOOT_VECTOR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_accept_i,
  input  logic        fetch_invalidate_i,
  input  logic        fetch_branch_i,
  input  logic [31:0] fetch_branch_pc_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
`ifdef RISCV_FETCH_FAULT_EN
  output logic        fetch_fault_o,
`endif
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic [31:0] icache_inst_i,
  input  logic        icache_error_i,
  output logic        icache_invalidate_o
);

  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d, branch_pc_q, branch_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d, skid_pc_q, skid_pc_d;
  logic        pending_q, pending_d, discard_q, discard_d, skid_valid_q, skid_valid_d;
  logic        hold_q, hold_d, branch_q, branch_d, invalidate_q;

  logic        resp_seen, resp_live, issue_stall, rd, req_accept, valid;
  logic [31:0] addr;

  assign resp_seen  = icache_valid_i & pending_q;
  assign resp_live  = resp_seen & ~discard_q;

`ifdef RISCV_FETCH_FAULT_EN
  logic fault_q, fault_d, skid_fault_q, skid_fault_d;
  // A faulting response stops issue in the same cycle it is delivered.
  assign issue_stall   = fault_q | (resp_live & icache_error_i);
  assign fault_d       = ~fetch_branch_i & issue_stall;
  assign skid_fault_d  = (valid & ~fetch_accept_i & ~skid_valid_q) ? icache_error_i
                                                                     : skid_fault_q;
  assign fetch_fault_o = valid & (skid_valid_q ? skid_fault_q : icache_error_i);
`else
  logic unused_error;
  assign unused_error = icache_error_i;
  assign issue_stall  = 1'b0;
`endif

  // Outputs are gated by reset so everything reads 0 while rst_i is low.
  assign rd = rst_i & (hold_q | (fetch_accept_i & ~skid_valid_q &
                                 (~pending_q | icache_valid_i) & ~issue_stall));
  assign addr       = {((branch_q & ~hold_q) ? branch_pc_q[31:2] : pc_q[31:2]), 2'b00};
  assign req_accept = rd & icache_accept_i;
  assign valid      = rst_i & ~fetch_branch_i & (skid_valid_q | resp_live);

  assign icache_rd_o         = rd;
  assign icache_pc_o         = rst_i ? addr : 32'h0;
  assign fetch_valid_o       = valid;
  assign fetch_instr_o       = ~rst_i ? 32'h0 : (skid_valid_q ? skid_instr_q : icache_inst_i);
  assign fetch_pc_o          = ~rst_i ? 32'h0 : (skid_valid_q ? skid_pc_q : req_pc_q);
  assign icache_invalidate_o = rst_i & invalidate_q;

  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    pending_d    = pending_q;
    discard_d    = discard_q;
    hold_d       = rd & ~icache_accept_i;
    branch_d     = branch_q;
    branch_pc_d  = branch_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (resp_seen) begin
      pending_d = 1'b0;
      if (discard_q) discard_d = 1'b0;
    end
    if (req_accept) begin
      pending_d = 1'b1;
      req_pc_d  = addr;
      branch_d  = 1'b0;
      // A held request that saw a redirect is stale; resume at the saved target.
      if (branch_q) begin
        pc_d      = branch_pc_q;
        discard_d = 1'b1;
      end else begin
        pc_d = addr + 32'd4;
      end
    end

    if (valid & fetch_accept_i) begin
      skid_valid_d = 1'b0;
    end else if (valid & ~skid_valid_q) begin
      skid_valid_d = 1'b1;
      skid_instr_d = icache_inst_i;
      skid_pc_d    = req_pc_q;
    end

    if (fetch_branch_i) begin
      skid_valid_d = 1'b0;
      if ((pending_q & ~icache_valid_i) | req_accept) discard_d = 1'b1;
      if (hold_q & ~icache_accept_i) begin
        branch_d    = 1'b1;
        branch_pc_d = {fetch_branch_pc_i[31:2], 2'b00};
      end else begin
        pc_d = {fetch_branch_pc_i[31:2], 2'b00};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q         <= {BOOT_VECTOR[31:2], 2'b00};
      req_pc_q     <= 32'h0;
      pending_q    <= 1'b0;
      discard_q    <= 1'b0;
      hold_q       <= 1'b0;
      branch_q     <= 1'b0;
      branch_pc_q  <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      invalidate_q <= 1'b0;
`ifdef RISCV_FETCH_FAULT_EN
      fault_q      <= 1'b0;
      skid_fault_q <= 1'b0;
`endif
    end else begin
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      pending_q    <= pending_d;
      discard_q    <= discard_d;
      hold_q       <= hold_d;
      branch_q     <= branch_d;
      branch_pc_q  <= branch_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      invalidate_q <= fetch_invalidate_i;
`ifdef RISCV_FETCH_FAULT_EN
      fault_q      <= fault_d;
      skid_fault_q <= skid_fault_d;
`endif
    end
  end

endmodule
